// File: rtl/itlb_assoc.sv
// ---------------------------------------------------------------------------
// itlb_assoc
//   Fully-associative instruction TLB caching Sv32-style leaf PTEs keyed by
//   {VPN, ASID}. Sits between the fetch address generator and the page-table
//   walker. A hit answers one cycle after the lookup is accepted. A miss starts
//   a walk request, waits for the walker, returns its result and installs it.
//   The TLB supports selective flush (all / by ASID / by VPN).
//
//   Optional feature macro: ITLB_SUPERPAGE_EN
//     When it is defined, each entry remembers whether it maps a megapage.
//     Megapage entries ignore the low VPN0_WD VPN bits on lookup and on VPN
//     flush, and the low VPN0_WD bits of the returned PPN come from the VPN.
//     When it is undefined, a megapage walk result is returned unchanged and
//     is never installed, so every entry is an exact 4 KiB match.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_lkp_valid/o_lkp_ready lookup handshake (ready only in IDLE, no flush)
//   i_lkp_vpn, i_lkp_asid   lookup key
//   o_rsp_valid             one-cycle response strobe
//   o_rsp_ppn, o_rsp_fault  translation result, fetch page fault
//   o_ptw_req_valid/i_ptw_req_ready/o_ptw_req_vpn   walk request
//   i_ptw_resp_valid/_pte/_fault/_mega              walk result
//   i_flush_valid           sfence.vma strobe
//   i_flush_asid_en/i_flush_asid, i_flush_vpn_en/i_flush_vpn   flush selectors
// ---------------------------------------------------------------------------
module itlb_assoc #(
   parameter int ENTRIES = 8,
   parameter int VPN_WD  = 20,
   parameter int VPN0_WD = 10,
   parameter int PPN_WD  = 22,
   parameter int ASID_WD = 9
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_lkp_valid,
   output logic               o_lkp_ready,
   input  logic [VPN_WD-1:0]  i_lkp_vpn,
   input  logic [ASID_WD-1:0] i_lkp_asid,
   output logic               o_rsp_valid,
   output logic [PPN_WD-1:0]  o_rsp_ppn,
   output logic               o_rsp_fault,
   output logic               o_ptw_req_valid,
   input  logic               i_ptw_req_ready,
   output logic [VPN_WD-1:0]  o_ptw_req_vpn,
   input  logic               i_ptw_resp_valid,
   input  logic [PPN_WD+9:0]  i_ptw_resp_pte,
   input  logic               i_ptw_resp_fault,
   input  logic               i_ptw_resp_mega,
   input  logic               i_flush_valid,
   input  logic               i_flush_asid_en,
   input  logic [ASID_WD-1:0] i_flush_asid,
   input  logic               i_flush_vpn_en,
   input  logic [VPN_WD-1:0]  i_flush_vpn
);

   localparam int IDX_WD = $clog2(ENTRIES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   // Entry storage: valid bits are reset, payload is not
   logic [ENTRIES-1:0] r_valid;
   logic [VPN_WD-1:0]  r_vpn  [ENTRIES];
   logic [ASID_WD-1:0] r_asid [ENTRIES];
   logic [PPN_WD-1:0]  r_ppn  [ENTRIES];
   logic [ENTRIES-1:0] r_g;
   logic [ENTRIES-1:0] r_x;
`ifdef ITLB_SUPERPAGE_EN
   logic [ENTRIES-1:0] r_mega;
`endif
   logic [IDX_WD-1:0]  r_rrPtr;

   // Control / registered outputs
   state_t             r_state;
   logic               r_rspValid;
   logic [PPN_WD-1:0]  r_rspPpn;
   logic               r_rspFault;
   logic               r_ptwReqValid;
   logic [VPN_WD-1:0]  r_ptwReqVpn;
   logic [ASID_WD-1:0] r_reqAsid;
   logic               r_flushSeen;

   // Combinational helpers
   logic [ENTRIES-1:0] w_entryMega;
   logic [ENTRIES-1:0] w_lkpMatch;
   logic [ENTRIES-1:0] w_flushKill;
   logic               w_hit;
   logic [IDX_WD-1:0]  w_hitIdx;
   logic [PPN_WD-1:0]  w_hitPpn;
   logic               w_freeAny;
   logic [IDX_WD-1:0]  w_freeIdx;
   logic [IDX_WD-1:0]  w_victimIdx;
   logic               w_accept;
   logic               w_install;
   logic               w_installMega;
   logic [PPN_WD-1:0]  w_ptePpn;
   logic               w_pteG;
   logic               w_pteX;
   logic [PPN_WD-1:0]  w_walkPpn;
   logic               w_unused;

   // VPN compare; a megapage entry only compares the VPN1 field
   function automatic logic vpnMatch(input logic [VPN_WD-1:0] a,
                                     input logic [VPN_WD-1:0] b,
                                     input logic              mega);
      if (mega)
         return a[VPN_WD-1:VPN0_WD] == b[VPN_WD-1:VPN0_WD];
      return a == b;
   endfunction

   // PTE field extraction: {ppn, rsw[1:0], d, a, g, u, x, w, r, v}
   assign w_ptePpn = i_ptw_resp_pte[PPN_WD+9:10];
   assign w_pteG   = i_ptw_resp_pte[5];
   assign w_pteX   = i_ptw_resp_pte[3];

`ifdef ITLB_SUPERPAGE_EN
   assign w_entryMega   = r_mega;
   assign w_installMega = i_ptw_resp_mega;
   assign w_unused      = ^{i_ptw_resp_pte[9:6], i_ptw_resp_pte[4], i_ptw_resp_pte[2:0]};
`else
   assign w_entryMega   = '0;
   assign w_installMega = 1'b0;
   assign w_unused      = ^{i_ptw_resp_pte[9:6], i_ptw_resp_pte[4], i_ptw_resp_pte[2:0],
                            i_ptw_resp_mega};
`endif

   // Lookups are only taken in IDLE, and a flush in the same cycle wins
   assign o_lkp_ready = (r_state == S_IDLE) && !i_flush_valid;
   assign w_accept    = i_lkp_valid && o_lkp_ready;

   // Per-entry lookup match and flush kill masks
   always_comb begin
      w_lkpMatch  = '0;
      w_flushKill = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         w_lkpMatch[i] = r_valid[i]
                       && vpnMatch(r_vpn[i], i_lkp_vpn, w_entryMega[i])
                       && (r_g[i] || (r_asid[i] == i_lkp_asid));
         // ASID-restricted flushes keep global entries
         w_flushKill[i] = i_flush_valid && r_valid[i]
                        && (!i_flush_asid_en || (!r_g[i] && (r_asid[i] == i_flush_asid)))
                        && (!i_flush_vpn_en || vpnMatch(r_vpn[i], i_flush_vpn, w_entryMega[i]));
      end
   end

   // Priority encoders: lowest matching entry wins, lowest free entry is filled first
   always_comb begin
      w_hit     = |w_lkpMatch;
      w_hitIdx  = '0;
      w_freeAny = ~&r_valid;
      w_freeIdx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (w_lkpMatch[i])
            w_hitIdx = IDX_WD'(i);
         if (!r_valid[i])
            w_freeIdx = IDX_WD'(i);
      end
      w_victimIdx = w_freeAny ? w_freeIdx : r_rrPtr;
   end

   // Hit PPN, with the page offset inside a megapage passed through from the VPN
   always_comb begin
      w_hitPpn = r_ppn[w_hitIdx];
      if (w_entryMega[w_hitIdx])
         w_hitPpn[VPN0_WD-1:0] = i_lkp_vpn[VPN0_WD-1:0];
   end

   // Walk result PPN; only rewritten for megapages when superpages are cached
   always_comb begin
      w_walkPpn = w_ptePpn;
      if (w_installMega)
         w_walkPpn[VPN0_WD-1:0] = r_ptwReqVpn[VPN0_WD-1:0];
   end

   // A walk result is cached only if the walker reported no fault and no flush
   // arrived between the lookup being accepted and the result coming back
   assign w_install = (r_state == S_WAIT) && i_ptw_resp_valid && !i_ptw_resp_fault
                   && !r_flushSeen && !i_flush_valid
`ifndef ITLB_SUPERPAGE_EN
                   && !i_ptw_resp_mega
`endif
                   ;

   // Valid bits and round-robin pointer. Flush and install never collide
   // because a same-cycle flush blocks the install.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= '0;
         r_rrPtr <= '0;
      end else begin
         r_valid <= r_valid & ~w_flushKill;
         if (w_install) begin
            r_valid[w_victimIdx] <= 1'b1;
            if (!w_freeAny)
               r_rrPtr <= r_rrPtr + IDX_WD'(1);
         end
      end
   end

   // Entry payload is written alongside the valid bit and needs no reset
   always_ff @(posedge i_clk) begin
      if (w_install) begin
         r_vpn[w_victimIdx]  <= r_ptwReqVpn;
         r_asid[w_victimIdx] <= r_reqAsid;
         r_ppn[w_victimIdx]  <= w_ptePpn;
         r_g[w_victimIdx]    <= w_pteG;
         r_x[w_victimIdx]    <= w_pteX;
`ifdef ITLB_SUPERPAGE_EN
         r_mega[w_victimIdx] <= i_ptw_resp_mega;
`endif
      end
   end

   // Miss/refill FSM with registered response and walk-request outputs.
   // The response strobe is set on the edge entering RESP (or after a hit)
   // and cleared by default one edge later, so it is always one cycle wide.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_rspValid    <= 1'b0;
         r_rspPpn      <= '0;
         r_rspFault    <= 1'b0;
         r_ptwReqValid <= 1'b0;
         r_ptwReqVpn   <= '0;
         r_reqAsid     <= '0;
         r_flushSeen   <= 1'b0;
      end else begin
         r_rspValid <= 1'b0;
         if (w_accept)
            r_flushSeen <= 1'b0;
         else if (i_flush_valid)
            r_flushSeen <= 1'b1;

         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_reqAsid <= i_lkp_asid;
                  if (w_hit) begin
                     r_rspValid <= 1'b1;
                     r_rspPpn   <= w_hitPpn;
                     r_rspFault <= !r_x[w_hitIdx];
                  end else begin
                     r_state       <= S_REQ;
                     r_ptwReqValid <= 1'b1;
                     r_ptwReqVpn   <= i_lkp_vpn;
                  end
               end
            end
            S_REQ: begin
               if (i_ptw_req_ready) begin
                  r_ptwReqValid <= 1'b0;
                  r_state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_ptw_resp_valid) begin
                  r_state    <= S_RESP;
                  r_rspValid <= 1'b1;
                  r_rspPpn   <= w_walkPpn;
                  r_rspFault <= i_ptw_resp_fault || !w_pteX;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_rsp_valid     = r_rspValid;
   assign o_rsp_ppn       = r_rspPpn;
   assign o_rsp_fault     = r_rspFault;
   assign o_ptw_req_valid = r_ptwReqValid;
   assign o_ptw_req_vpn   = r_ptwReqVpn;

endmodule

// File: tb/tb_itlb_assoc.sv
// ---------------------------------------------------------------------------
// tb_itlb_assoc
//   Directed testbench for itlb_assoc with the default parameters. The bench
//   plays the page-table walker and checks responses against hand-computed
//   values. Megapage behaviour is checked for whichever build is compiled
//   (ITLB_SUPERPAGE_EN defined or not).
// ---------------------------------------------------------------------------
module tb_itlb_assoc;

   localparam int ENTRIES = 8;
   localparam int VPN_WD  = 20;
   localparam int VPN0_WD = 10;
   localparam int PPN_WD  = 22;
   localparam int ASID_WD = 9;

   logic               clock = 1'b0;
   logic               reset;
   logic               lkpValid;
   logic               lkpReady;
   logic [VPN_WD-1:0]  lkpVpn;
   logic [ASID_WD-1:0] lkpAsid;
   logic               rspValid;
   logic [PPN_WD-1:0]  rspPpn;
   logic               rspFault;
   logic               ptwReqValid;
   logic               ptwReqReady;
   logic [VPN_WD-1:0]  ptwReqVpn;
   logic               ptwRespValid;
   logic [PPN_WD+9:0]  ptwRespPte;
   logic               ptwRespFault;
   logic               ptwRespMega;
   logic               flushValid;
   logic               flushAsidEn;
   logic [ASID_WD-1:0] flushAsid;
   logic               flushVpnEn;
   logic [VPN_WD-1:0]  flushVpn;

   int compared   = 0;
   int mismatched = 0;

   // Results of the most recent doLookup call
   logic              resMissed;
   logic [VPN_WD-1:0] resWalkVpn;
   logic              resHeld;
   logic              resRsp;
   logic [PPN_WD-1:0] resPpn;
   logic              resFault;

   itlb_assoc #(
      .ENTRIES (ENTRIES),
      .VPN_WD  (VPN_WD),
      .VPN0_WD (VPN0_WD),
      .PPN_WD  (PPN_WD),
      .ASID_WD (ASID_WD)
   ) dut (
      .i_clk            (clock),
      .i_rst            (reset),
      .i_lkp_valid      (lkpValid),
      .o_lkp_ready      (lkpReady),
      .i_lkp_vpn        (lkpVpn),
      .i_lkp_asid       (lkpAsid),
      .o_rsp_valid      (rspValid),
      .o_rsp_ppn        (rspPpn),
      .o_rsp_fault      (rspFault),
      .o_ptw_req_valid  (ptwReqValid),
      .i_ptw_req_ready  (ptwReqReady),
      .o_ptw_req_vpn    (ptwReqVpn),
      .i_ptw_resp_valid (ptwRespValid),
      .i_ptw_resp_pte   (ptwRespPte),
      .i_ptw_resp_fault (ptwRespFault),
      .i_ptw_resp_mega  (ptwRespMega),
      .i_flush_valid    (flushValid),
      .i_flush_asid_en  (flushAsidEn),
      .i_flush_asid     (flushAsid),
      .i_flush_vpn_en   (flushVpnEn),
      .i_flush_vpn      (flushVpn)
   );

   always #5 clock = ~clock;

   // Leaf PTE {ppn, rsw, d, a, g, u, x, w, r, v} with d/a/r/v set
   function automatic logic [PPN_WD+9:0] mkPte(input logic [PPN_WD-1:0] ppn,
                                               input logic g, input logic x);
      return {ppn, 2'b00, 1'b1, 1'b1, g, 1'b0, x, 1'b0, 1'b1, 1'b1};
   endfunction

   // One lookup; on a miss the bench acts as walker: holds ready low one
   // cycle, accepts, optionally flushes during WAIT, then returns the PTE.
   task automatic doLookup(input logic [VPN_WD-1:0] vpn, input logic [ASID_WD-1:0] asid,
                           input logic [PPN_WD+9:0] pte, input logic walkFault,
                           input logic mega, input logic flushInWait);
      int n;
      resMissed = 1'b0; resWalkVpn = '0; resHeld = 1'b0;
      resRsp = 1'b0; resPpn = '0; resFault = 1'b0;
      @(negedge clock);
      lkpValid = 1'b1; lkpVpn = vpn; lkpAsid = asid;
      n = 0;
      while (!lkpReady && n < 20) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      lkpValid = 1'b0;
      if (rspValid) begin
         resRsp = 1'b1; resPpn = rspPpn; resFault = rspFault; resMissed = ptwReqValid;
      end else if (ptwReqValid) begin
         resMissed = 1'b1; resWalkVpn = ptwReqVpn;
         @(negedge clock);
         resHeld = ptwReqValid && (ptwReqVpn == resWalkVpn);
         ptwReqReady = 1'b1;
         @(negedge clock);
         ptwReqReady = 1'b0;
         if (flushInWait) begin
            flushValid = 1'b1; flushAsidEn = 1'b0; flushVpnEn = 1'b0;
            @(negedge clock);
            flushValid = 1'b0;
         end
         ptwRespValid = 1'b1; ptwRespPte = pte; ptwRespFault = walkFault; ptwRespMega = mega;
         @(negedge clock);
         ptwRespValid = 1'b0; ptwRespFault = 1'b0; ptwRespMega = 1'b0;
         if (rspValid) begin
            resRsp = 1'b1; resPpn = rspPpn; resFault = rspFault;
         end
      end
   endtask

   task automatic doFlush(input logic asidEn, input logic [ASID_WD-1:0] asid,
                          input logic vpnEn, input logic [VPN_WD-1:0] vpn);
      @(negedge clock);
      flushValid = 1'b1; flushAsidEn = asidEn; flushAsid = asid;
      flushVpnEn = vpnEn; flushVpn = vpn;
      @(negedge clock);
      flushValid = 1'b0; flushAsidEn = 1'b0; flushVpnEn = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      compared++;
      if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rspValid); end
      compared++;
      if (rspPpn !== '0) begin mismatched++; $display("[TB] FAIL reset_rsp_ppn: got %h want 0", rspPpn); end
      compared++;
      if (rspFault !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsp_fault: got %b want 0", rspFault); end
      compared++;
      if (ptwReqValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ptw_valid: got %b want 0", ptwReqValid); end
      compared++;
      if (ptwReqVpn !== '0) begin mismatched++; $display("[TB] FAIL reset_ptw_vpn: got %h want 0", ptwReqVpn); end
      reset = 1'b0;
      @(negedge clock);
      compared++;
      if (lkpReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_lkp_ready: got %b want 1", lkpReady); end
   endtask

   task automatic test_cold_miss;
      doLookup(20'h12345, 9'd1, mkPte(22'h0ABCD, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL cold_miss: got %b want 1", resMissed); end
      compared++;
      if (resWalkVpn !== 20'h12345) begin mismatched++; $display("[TB] FAIL cold_walk_vpn: got %h want 12345", resWalkVpn); end
      compared++;
      if (resHeld !== 1'b1) begin mismatched++; $display("[TB] FAIL cold_req_held: got %b want 1", resHeld); end
      compared++;
      if (resRsp !== 1'b1) begin mismatched++; $display("[TB] FAIL cold_rsp: got %b want 1", resRsp); end
      compared++;
      if (resPpn !== 22'h0ABCD) begin mismatched++; $display("[TB] FAIL cold_ppn: got %h want 0abcd", resPpn); end
      compared++;
      if (resFault !== 1'b0) begin mismatched++; $display("[TB] FAIL cold_fault: got %b want 0", resFault); end
   endtask

   task automatic test_hit_and_asid;
      doLookup(20'h12345, 9'd1, mkPte(22'h3FFFF, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resRsp !== 1'b1) begin mismatched++; $display("[TB] FAIL hit_1cycle: missed=%b rsp=%b want 0/1", resMissed, resRsp); end
      compared++;
      if (resPpn !== 22'h0ABCD) begin mismatched++; $display("[TB] FAIL hit_ppn: got %h want 0abcd", resPpn); end
      doLookup(20'h12345, 9'd2, mkPte(22'h01111, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL other_asid_miss: got %b want 1", resMissed); end
      // Non-executable page is cached and faults on every hit
      doLookup(20'h00300, 9'd1, mkPte(22'h00333, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resFault !== 1'b1 || resPpn !== 22'h00333) begin mismatched++; $display("[TB] FAIL nx_walk: fault=%b ppn=%h want 1/00333", resFault, resPpn); end
      doLookup(20'h00300, 9'd1, mkPte(22'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resFault !== 1'b1) begin mismatched++; $display("[TB] FAIL nx_hit: missed=%b fault=%b want 0/1", resMissed, resFault); end
   endtask

   task automatic test_flush_selectors;
      doFlush(1'b0, 9'd0, 1'b0, 20'h0);
      doLookup(20'h12345, 9'd1, mkPte(22'h0ABCD, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_all: missed=%b want 1", resMissed); end
      doLookup(20'h00100, 9'd1, mkPte(22'h00AAA, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
      doLookup(20'h00200, 9'd1, mkPte(22'h00BBB, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      doLookup(20'h00100, 9'd7, mkPte(22'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resPpn !== 22'h00AAA) begin mismatched++; $display("[TB] FAIL global_bypass: missed=%b ppn=%h want 0/00aaa", resMissed, resPpn); end
      doFlush(1'b1, 9'd1, 1'b0, 20'h0);
      doLookup(20'h00100, 9'd1, mkPte(22'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resPpn !== 22'h00AAA) begin mismatched++; $display("[TB] FAIL asid_flush_global: missed=%b ppn=%h want 0/00aaa", resMissed, resPpn); end
      doLookup(20'h00200, 9'd1, mkPte(22'h00BBB, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL asid_flush_private: missed=%b want 1", resMissed); end
      doFlush(1'b0, 9'd0, 1'b1, 20'h00100);
      doLookup(20'h00100, 9'd1, mkPte(22'h00AAA, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL vpn_flush: missed=%b want 1", resMissed); end
   endtask

   task automatic test_fill_evict;
      int misses;
      doFlush(1'b0, 9'd0, 1'b0, 20'h0);
      misses = 0;
      for (int i = 0; i <= ENTRIES; i++) begin
         doLookup(VPN_WD'(32'h20000 + i), 9'd1, mkPte(PPN_WD'(32'h100 + i), 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
         if (resMissed) misses++;
      end
      compared++;
      if (misses !== ENTRIES + 1) begin mismatched++; $display("[TB] FAIL fill_misses: got %0d want %0d", misses, ENTRIES + 1); end
      // Entry 0 was the first victim; this refill evicts entry 1 (0x20001)
      doLookup(20'h20000, 9'd1, mkPte(22'h00100, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL evict_first: missed=%b want 1", resMissed); end
      doLookup(20'h20002, 9'd1, mkPte(22'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resPpn !== 22'h00102) begin mismatched++; $display("[TB] FAIL keep_20002: missed=%b ppn=%h want 0/00102", resMissed, resPpn); end
      doLookup(20'h20008, 9'd1, mkPte(22'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resPpn !== 22'h00108) begin mismatched++; $display("[TB] FAIL keep_20008: missed=%b ppn=%h want 0/00108", resMissed, resPpn); end
      doLookup(20'h20001, 9'd1, mkPte(22'h00101, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_advance: missed=%b want 1", resMissed); end
   endtask

   task automatic test_back_to_back;
      logic [VPN_WD-1:0] vpns [3];
      logic [PPN_WD-1:0] ppns [3];
      vpns = '{20'h20003, 20'h20004, 20'h20005};
      ppns = '{22'h00103, 22'h00104, 22'h00105};
      @(negedge clock);
      lkpValid = 1'b1; lkpVpn = vpns[0]; lkpAsid = 9'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         compared++;
         if (rspValid !== 1'b1 || rspPpn !== ppns[k]) begin
            mismatched++;
            $display("[TB] FAIL b2b_hit%0d: valid=%b ppn=%h want 1/%h", k, rspValid, rspPpn, ppns[k]);
         end
         if (k < 2) lkpVpn = vpns[k + 1];
      end
      lkpValid = 1'b0;
   endtask

   task automatic test_flush_priority;
      @(negedge clock);
      flushValid = 1'b1; flushVpnEn = 1'b1; flushVpn = 20'h7FFFF;
      lkpValid = 1'b1; lkpVpn = 20'h20003; lkpAsid = 9'd1;
      #1;
      compared++;
      if (lkpReady !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_blocks_ready: got %b want 0", lkpReady); end
      @(negedge clock);
      flushValid = 1'b0; flushVpnEn = 1'b0; lkpValid = 1'b0;
      compared++;
      if (rspValid !== 1'b0 || ptwReqValid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_accept: rsp=%b req=%b want 0/0", rspValid, ptwReqValid); end
      doLookup(20'h20003, 9'd1, mkPte(22'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resPpn !== 22'h00103) begin mismatched++; $display("[TB] FAIL vpn_flush_other: missed=%b ppn=%h want 0/00103", resMissed, resPpn); end
   endtask

   task automatic test_flush_in_wait;
      doLookup(20'h04444, 9'd1, mkPte(22'h04040, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
      compared++;
      if (resRsp !== 1'b1 || resPpn !== 22'h04040 || resFault !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL wait_flush_rsp: rsp=%b ppn=%h fault=%b want 1/04040/0", resRsp, resPpn, resFault);
      end
      doLookup(20'h04444, 9'd1, mkPte(22'h04040, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1 || resWalkVpn !== 20'h04444) begin mismatched++; $display("[TB] FAIL wait_flush_drop: missed=%b vpn=%h want 1/04444", resMissed, resWalkVpn); end
   endtask

   task automatic test_walk_fault;
      doLookup(20'h05555, 9'd1, mkPte(22'h00555, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
      compared++;
      if (resRsp !== 1'b1 || resFault !== 1'b1) begin mismatched++; $display("[TB] FAIL walk_fault_rsp: rsp=%b fault=%b want 1/1", resRsp, resFault); end
      doLookup(20'h05555, 9'd1, mkPte(22'h00555, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL walk_fault_uncached: missed=%b want 1", resMissed); end
   endtask

   task automatic test_mega;
      doLookup(20'h00801, 9'd1, mkPte(22'h00400, 1'b0, 1'b1), 1'b0, 1'b1, 1'b0);
`ifdef ITLB_SUPERPAGE_EN
      compared++;
      if (resPpn !== 22'h00401) begin mismatched++; $display("[TB] FAIL mega_walk_ppn: got %h want 00401", resPpn); end
      doLookup(20'h00BFF, 9'd1, mkPte(22'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b0 || resPpn !== 22'h007FF) begin mismatched++; $display("[TB] FAIL mega_hit: missed=%b ppn=%h want 0/007ff", resMissed, resPpn); end
      doLookup(20'h00C01, 9'd1, mkPte(22'h00C01, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL mega_other_region: missed=%b want 1", resMissed); end
`else
      compared++;
      if (resPpn !== 22'h00400) begin mismatched++; $display("[TB] FAIL mega_walk_ppn: got %h want 00400", resPpn); end
      doLookup(20'h00801, 9'd1, mkPte(22'h00400, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL mega_not_cached: missed=%b want 1", resMissed); end
`endif
   endtask

   task automatic test_reset_midwalk;
      doLookup(20'h07777, 9'd1, mkPte(22'h00777, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      lkpValid = 1'b1; lkpVpn = 20'h06666; lkpAsid = 9'd1;
      @(negedge clock);
      lkpValid = 1'b0;
      compared++;
      if (ptwReqValid !== 1'b1) begin mismatched++; $display("[TB] FAIL midwalk_req: got %b want 1", ptwReqValid); end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      compared++;
      if (ptwReqValid !== 1'b0 || ptwReqVpn !== '0) begin mismatched++; $display("[TB] FAIL midwalk_reset: valid=%b vpn=%h want 0/0", ptwReqValid, ptwReqVpn); end
      ptwRespValid = 1'b1; ptwRespPte = mkPte(22'h00666, 1'b0, 1'b1);
      @(negedge clock);
      ptwRespValid = 1'b0;
      compared++;
      if (rspValid !== 1'b0 || lkpReady !== 1'b1) begin mismatched++; $display("[TB] FAIL late_resp: rsp=%b ready=%b want 0/1", rspValid, lkpReady); end
      doLookup(20'h07777, 9'd1, mkPte(22'h00777, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      compared++;
      if (resMissed !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_clears_entries: missed=%b want 1", resMissed); end
   endtask

   // Runs every scenario in order and prints the summary
   initial begin
      reset = 1'b1; lkpValid = 1'b0; lkpVpn = '0; lkpAsid = '0;
      ptwReqReady = 1'b0; ptwRespValid = 1'b0; ptwRespPte = '0;
      ptwRespFault = 1'b0; ptwRespMega = 1'b0;
      flushValid = 1'b0; flushAsidEn = 1'b0; flushAsid = '0;
      flushVpnEn = 1'b0; flushVpn = '0;
      $display("[TB] itlb_assoc directed test start");
      test_reset();
      test_cold_miss();
      test_hit_and_asid();
      test_flush_selectors();
      test_fill_evict();
      test_back_to_back();
      test_flush_priority();
      test_flush_in_wait();
      test_walk_fault();
      test_mega();
      test_reset_midwalk();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Guards against a stuck simulation
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
